// File: rtl/fft_frame_sequencer_if.sv
// Command and status bundle between the register decode, the capture/FFT
// datapath and the frame sequencer.
interface fft_frame_sequencer_if #(
    parameter int NUM_CH = 4
);
    logic              start;
    logic              abort;
    logic              continuous;
    logic              irq_clear;
    logic              cap_ready_async;
    logic [NUM_CH-1:0] fft_done;

    logic              go;
    logic              busy;
    logic              irq;
    logic [2:0]        state;
    logic [15:0]       frame_count;
    logic [1:0]        err;
    logic [NUM_CH-1:0] done_mask;

    modport master (
        output start, abort, continuous, irq_clear, cap_ready_async, fft_done,
        input  go, busy, irq, state, frame_count, err, done_mask
    );

    modport slave (
        input  start, abort, continuous, irq_clear, cap_ready_async, fft_done,
        output go, busy, irq, state, frame_count, err, done_mask
    );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frame-level controller for the microphone capture + FFT path: stretches the
// start command into go, tracks capture/FFT completion, counts frames, raises irq.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE    0 | waiting for start
// ARM     1 | go held high for the stretch, then wait for capture to leave READ
// CAPTURE 2 | waiting for rising edge of the synchronized ready level
// FFT     3 | collecting per-channel done pulses into done_mask
// DONE    4 | one cycle: irq set, frame_count incremented
// GAP     5 | idle spacing before auto re-arm in continuous mode
// ERROR   6 | timeout; err held until start or abort
module fft_frame_sequencer #(
    parameter int NUM_CH         = 4,
    parameter int STRETCH_CYCLES = 17,
    parameter int CAP_TIMEOUT    = 2_500_000,
    parameter int FFT_TIMEOUT    = 65_536,
    parameter int FRAME_GAP      = 64
) (
    input logic                   clk,
    input logic                   rst_n,
    fft_frame_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_CAPTURE = 3'd2,
        S_FFT     = 3'd3,
        S_DONE    = 3'd4,
        S_GAP     = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    localparam int SMAX = (STRETCH_CYCLES > FRAME_GAP) ? STRETCH_CYCLES : FRAME_GAP;
    localparam int TMAX = (CAP_TIMEOUT > FFT_TIMEOUT) ? CAP_TIMEOUT : FFT_TIMEOUT;
    localparam int SW   = $clog2(SMAX + 1);
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_CYCLES);
    localparam logic [SW-1:0] GAP_LOAD     = SW'(FRAME_GAP - 1);
    localparam logic [SW-1:0] S_ONE        = SW'(1);
    localparam logic [TW-1:0] CAP_LOAD     = TW'(CAP_TIMEOUT - 1);
    localparam logic [TW-1:0] FFT_LOAD     = TW'(FFT_TIMEOUT - 1);
    localparam logic [TW-1:0] T_ONE        = TW'(1);

    state_t            state_q, state_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] mask_or;
    logic [1:0]        err_q, err_d;
    logic [15:0]       fc_q, fc_d;
    logic              irq_q, irq_d;
    logic              go_q, go_d;
    logic              busy_q, busy_d;
    logic              irq_set;
    logic              arm;

    // [0],[1] synchronize the SCK-domain ready level, [2] delays it for edge detect
    logic [2:0] sync_q;
    logic       ready_s;
    logic       ready_rise;

    assign ready_s    = sync_q[1];
    assign ready_rise = sync_q[1] & ~sync_q[2];
    assign mask_or    = mask_q | bus.fft_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1], sync_q[0], bus.cap_ready_async};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tmo_q   <= '0;
            mask_q  <= '0;
            err_q   <= 2'd0;
            fc_q    <= 16'd0;
            irq_q   <= 1'b0;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
            fc_q    <= fc_d;
            irq_q   <= irq_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        mask_d  = mask_q;
        err_d   = err_q;
        fc_d    = fc_q;
        irq_set = 1'b0;
        arm     = 1'b0;

        if (bus.abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            tmo_d   = '0;
            mask_d  = '0;
            err_d   = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) arm = 1'b1;
                end
                S_ARM: begin
                    if (cnt_q != '0) cnt_d = cnt_q - S_ONE;
                    // Timeout only runs while capture is still parked with ready high
                    if (!ready_s) begin
                        tmo_d = CAP_LOAD;
                        if (cnt_q == '0) state_d = S_CAPTURE;
                    end else if (tmo_q == '0) begin
                        state_d = S_ERROR;
                        err_d   = 2'd1;
                        irq_set = 1'b1;
                    end else begin
                        tmo_d = tmo_q - T_ONE;
                    end
                end
                S_CAPTURE: begin
                    if (ready_rise) begin
                        state_d = S_FFT;
                        tmo_d   = FFT_LOAD;
                    end else if (tmo_q == '0) begin
                        state_d = S_ERROR;
                        err_d   = 2'd1;
                        irq_set = 1'b1;
                    end else begin
                        tmo_d = tmo_q - T_ONE;
                    end
                end
                S_FFT: begin
                    mask_d = mask_or;
                    if (&mask_or) begin
                        state_d = S_DONE;
                    end else if (tmo_q == '0) begin
                        state_d = S_ERROR;
                        err_d   = 2'd2;
                        irq_set = 1'b1;
                    end else begin
                        tmo_d = tmo_q - T_ONE;
                    end
                end
                S_DONE: begin
                    fc_d    = fc_q + 16'd1;
                    irq_set = 1'b1;
                    if (bus.continuous) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_GAP: begin
                    if (!bus.continuous) state_d = S_IDLE;
                    else if (cnt_q == '0) arm = 1'b1;
                    else cnt_d = cnt_q - S_ONE;
                end
                S_ERROR: begin
                    if (bus.start) arm = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase

            if (arm) begin
                state_d = S_ARM;
                cnt_d   = STRETCH_LOAD;
                tmo_d   = CAP_LOAD;
                mask_d  = '0;
                err_d   = 2'd0;
            end
        end

        // A set in the same cycle as a clear wins
        irq_d  = irq_set ? 1'b1 : (bus.irq_clear ? 1'b0 : irq_q);
        go_d   = (state_d == S_ARM) && (cnt_d != '0);
        busy_d = !((state_d == S_IDLE) || (state_d == S_ERROR));
    end

    assign bus.go          = go_q;
    assign bus.busy        = busy_q;
    assign bus.irq         = irq_q;
    assign bus.state       = state_q;
    assign bus.frame_count = fc_q;
    assign bus.err         = err_q;
    assign bus.done_mask   = mask_q;

endmodule
